// File: rtl/zone_color_sequencer.sv
// Zone colour sequencer: a debounced button press or a periodic frame tick
// captures the free-running colour into one of four shadow slots. The shadow
// slots are copied to the active slots only at frame start, so a zone never
// changes colour part-way through a frame.
module zone_color_sequencer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int AUTO_PERIOD     = 60
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        swap_in,
  input  logic        auto_en_in,
  input  logic        frame_start_in,
  input  logic [23:0] new_color_in,
  input  logic [1:0]  zone_in,
  output logic [23:0] color_out,
  output logic [1:0]  load_sel_out,
  output logic        pending_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]    AUTO_LAST = 8'(AUTO_PERIOD - 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] DEBOUNCE = 2'd1;
  localparam logic [1:0] HELD     = 2'd2;

  // Element gi is the power-up colour of slot gi.
  localparam logic [3:0][23:0] SLOT_DEFAULTS =
    {24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000};

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [7:0]    auto_cnt_q, auto_cnt_d;
  logic [1:0]    load_sel_q, load_sel_d;
  logic          pending_q, pending_d;
  logic [23:0]   color_q, color_d;

  logic          press_evt;
  logic          auto_evt;
  logic          capture;
  logic          commit;
  logic [23:0]   active_slot [4];

  // Debounce FSM: a press fires once, on the edge the count of consecutive
  // high samples reaches DEBOUNCE_CYCLES; HELD blocks repeats until release.
  always_comb begin
    state_d   = state_q;
    deb_cnt_d = deb_cnt_q;
    press_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (swap_in) begin
          state_d   = DEBOUNCE;
          deb_cnt_d = CW'(1);
        end
      end
      DEBOUNCE: begin
        if (!swap_in) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
          press_evt = 1'b1;
          state_d   = HELD;
          deb_cnt_d = deb_cnt_q + CW'(1);
        end else begin
          deb_cnt_d = deb_cnt_q + CW'(1);
        end
      end
      HELD: begin
        if (!swap_in) begin
          state_d   = IDLE;
          deb_cnt_d = '0;
        end
      end
      default: begin
        state_d   = IDLE;
        deb_cnt_d = '0;
      end
    endcase
  end

  // Frame counter for automatic captures; held at zero while disabled.
  always_comb begin
    auto_cnt_d = auto_cnt_q;
    auto_evt   = 1'b0;
    if (!auto_en_in) begin
      auto_cnt_d = '0;
    end else if (frame_start_in) begin
      if (auto_cnt_q == AUTO_LAST) begin
        auto_evt   = 1'b1;
        auto_cnt_d = '0;
      end else begin
        auto_cnt_d = auto_cnt_q + 8'd1;
      end
    end
  end

  // Capture/commit bookkeeping. A capture on a commit edge wins the pending
  // flag so that colour is still committed at the next frame start.
  always_comb begin
    capture    = press_evt | auto_evt;
    commit     = frame_start_in & pending_q;
    load_sel_d = capture ? load_sel_q + 2'd1 : load_sel_q;
    if (capture) begin
      pending_d = 1'b1;
    end else if (frame_start_in) begin
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    color_d = active_slot[zone_in];
  end

  // Control state and the registered pixel colour.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= IDLE;
      deb_cnt_q  <= '0;
      auto_cnt_q <= '0;
      load_sel_q <= '0;
      pending_q  <= 1'b0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      deb_cnt_q  <= deb_cnt_d;
      auto_cnt_q <= auto_cnt_d;
      load_sel_q <= load_sel_d;
      pending_q  <= pending_d;
      color_q    <= color_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slot
      logic [23:0] shadow_q, shadow_d;
      logic [23:0] active_q, active_d;

      assign shadow_d = (capture && load_sel_q == 2'(gi)) ? new_color_in : shadow_q;
      // Commit copies the shadow value held before this edge.
      assign active_d = commit ? shadow_q : active_q;

      // Per-slot shadow and active colour registers.
      always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
          shadow_q <= SLOT_DEFAULTS[gi];
          active_q <= SLOT_DEFAULTS[gi];
        end else begin
          shadow_q <= shadow_d;
          active_q <= active_d;
        end
      end

      assign active_slot[gi] = active_q;
    end
  endgenerate

  assign color_out    = color_q;
  assign load_sel_out = load_sel_q;
  assign pending_out  = pending_q;

endmodule

// File: tb/tb_zone_color_sequencer.sv
// Directed bench for zone_color_sequencer (DEBOUNCE_CYCLES=16, AUTO_PERIOD=3).
module tb_zone_color_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        swap = 1'b0;
  logic        auto_en = 1'b0;
  logic        frame = 1'b0;
  logic [23:0] new_color = 24'h0;
  logic [1:0]  zone = 2'd2;
  logic [23:0] color;
  logic [1:0]  load_sel;
  logic        pending;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  zone_color_sequencer #(
    .DEBOUNCE_CYCLES(16),
    .AUTO_PERIOD(3)
  ) dut (
    .clk_in        (clk),
    .reset_in      (rst),
    .swap_in       (swap),
    .auto_en_in    (auto_en),
    .frame_start_in(frame),
    .new_color_in  (new_color),
    .zone_in       (zone),
    .color_out     (color),
    .load_sel_out  (load_sel),
    .pending_out   (pending)
  );

  // One rising edge; returns 1 time unit later so outputs are settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-16s observed %h expected %h", tag, obs, exp);
  endtask

  // Qualified press: 15 high edges, the 16th captures col (optionally with a frame pulse), then release.
  task automatic press(input logic [23:0] col, input logic with_frame);
    swap = 1'b1;
    repeat (15) step();
    new_color = col;
    frame = with_frame;
    step();
    frame = 1'b0;
    new_color = 24'hDEAD00;
    swap = 1'b0;
    step();
  endtask

  task automatic frame_pulse();
    frame = 1'b1;
    step();
    frame = 1'b0;
  endtask

  // Reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [23:0] cols [5];
    logic [1:0]  exp_sel [5];
    logic [23:0] exp_zone [4];
    logic [23:0] dflt [4];

    cols     = '{24'h111111, 24'h222222, 24'h333333, 24'h444444, 24'h555555};
    exp_sel  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_zone = '{24'h555555, 24'h222222, 24'h333333, 24'h444444};
    dflt     = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFFFF};

    // Reset state
    step(); step();
    check("rst_color", color, 24'h000000);
    check("rst_sel", {22'd0, load_sel}, 24'd0);
    check("rst_pend", {23'd0, pending}, 24'd0);
    rst = 1'b0;

    // Defaults after reset, latency 1
    step();
    check("zone2_dflt", color, 24'h0000FF);
    check("sel_after_rst", {22'd0, load_sel}, 24'd0);
    check("pend_after_rst", {23'd0, pending}, 24'd0);
    for (int i = 0; i < 4; i++) begin
      zone = 2'(i);
      step();
      check("zone_dflt", color, dflt[i]);
    end

    // 15 high cycles: no capture
    swap = 1'b1;
    repeat (15) step();
    swap = 1'b0;
    step();
    check("short_sel", {22'd0, load_sel}, 24'd0);
    check("short_pend", {23'd0, pending}, 24'd0);

    // 40 high cycles: one capture of the qualifying-cycle colour
    swap = 1'b1;
    repeat (15) step();
    new_color = 24'h123456;
    step();
    check("qual_sel", {22'd0, load_sel}, 24'd1);
    check("qual_pend", {23'd0, pending}, 24'd1);
    new_color = 24'hABCDEF;
    repeat (24) step();
    swap = 1'b0;
    step();
    check("long_sel", {22'd0, load_sel}, 24'd1);
    zone = 2'd0;
    frame_pulse();
    check("commit_pend", {23'd0, pending}, 24'd0);
    check("commit_edge_col", color, 24'hFF0000);
    step();
    check("zone0_new", color, 24'h123456);

    // Five presses from a fresh reset
    pulse_reset();
    check("sel_reset2", {22'd0, load_sel}, 24'd0);
    for (int i = 0; i < 5; i++) begin
      press(cols[i], 1'b0);
      check("press_sel", {22'd0, load_sel}, {22'd0, exp_sel[i]});
    end
    check("five_pend", {23'd0, pending}, 24'd1);
    frame_pulse();
    for (int i = 0; i < 4; i++) begin
      zone = 2'(i);
      step();
      check("five_zone", color, exp_zone[i]);
    end

    // Auto captures with a press coinciding with the 3rd frame
    auto_en = 1'b1;
    frame_pulse();
    frame_pulse();
    press(24'hAAAAAA, 1'b0);
    check("pre_auto_sel", {22'd0, load_sel}, 24'd2);
    check("pre_auto_pend", {23'd0, pending}, 24'd1);
    press(24'hBBBBBB, 1'b1);
    check("coinc_sel", {22'd0, load_sel}, 24'd3);
    check("coinc_pend", {23'd0, pending}, 24'd1);
    zone = 2'd1;
    step();
    check("coinc_zone1", color, 24'hAAAAAA);
    zone = 2'd2;
    step();
    check("coinc_zone2_old", color, 24'h333333);
    frame_pulse();
    check("f4_pend", {23'd0, pending}, 24'd0);
    check("f4_sel", {22'd0, load_sel}, 24'd3);
    step();
    check("f4_zone2", color, 24'hBBBBBB);
    new_color = 24'h5A5A5A;
    frame_pulse();
    check("f5_sel", {22'd0, load_sel}, 24'd3);
    frame_pulse();
    check("auto_sel", {22'd0, load_sel}, 24'd0);
    check("auto_pend", {23'd0, pending}, 24'd1);

    // Asynchronous reset while pending
    #2 rst = 1'b1;
    #1;
    check("async_color", color, 24'h000000);
    check("async_sel", {22'd0, load_sel}, 24'd0);
    check("async_pend", {23'd0, pending}, 24'd0);
    rst = 1'b0;
    auto_en = 1'b0;
    zone = 2'd3;
    step();
    check("async_zone3", color, 24'hFFFFFF);
    frame_pulse();
    zone = 2'd2;
    step();
    check("nopend_zone2", color, 24'h0000FF);

    // Reset mid-debounce discards the partial press
    swap = 1'b1;
    repeat (10) step();
    pulse_reset();
    repeat (6) step();
    swap = 1'b0;
    step();
    check("middeb_sel", {22'd0, load_sel}, 24'd0);
    check("middeb_pend", {23'd0, pending}, 24'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/zone_color_sequencer.md
ZONE_COLOR_SEQUENCER -- requirements
Module: zone_color_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16, number of consecutive high cycles that qualify a swap press (legal range 2..2^20).
REQ-002 Parameter AUTO_PERIOD, default 60, number of frame_start_in pulses between automatic captures (legal range 1..255).
REQ-003 clk_in  input  1  single system/pixel clock; all state updates on its rising edge.
REQ-004 reset_in  input  1  asynchronous, active-high reset.
REQ-005 swap_in  input  1  raw user button, active-high, already synchronised, not debounced.
REQ-006 auto_en_in  input  1  when high, automatic captures run every AUTO_PERIOD frames.
REQ-007 frame_start_in  input  1  one-cycle pulse at start of vertical blanking.
REQ-008 new_color_in  input  24  free-running colour generator value, {R,G,B}, 8 bits each.
REQ-009 zone_in  input  2  screen quadrant currently being drawn.
REQ-010 color_out  output  24  colour for the current pixel.
REQ-011 load_sel_out  output  2  index of the zone slot the next capture writes.
REQ-012 pending_out  output  1  high while captured colours wait for commit.

Function
REQ-013 Debounce FSM, 3 states: IDLE, DEBOUNCE, HELD.
REQ-014 IDLE -> DEBOUNCE when swap_in=1; the internal counter loads 1.
REQ-015 In DEBOUNCE: if swap_in=0, go to IDLE; otherwise increment the counter. When the counter reaches DEBOUNCE_CYCLES, emit one press event and go to HELD.
REQ-016 HELD -> IDLE when swap_in=0. No further press events occur while in HELD.
REQ-017 Auto counter increments on each frame_start_in while auto_en_in=1.
REQ-018 When the auto counter reaches AUTO_PERIOD, it emits an auto event and clears to 0.
REQ-019 auto_en_in=0 holds the auto counter at 0.
REQ-020 Capture event = press event OR auto event.
REQ-021 Simultaneous press and auto events produce exactly one capture.
REQ-022 A capture writes new_color_in into shadow[load_sel_out], sets pending, and advances load_sel_out by 1 mod 4 (3 wraps to 0).
REQ-023 A frame_start_in with pending=1 copies all four shadow slots to the active slots.
REQ-024 The commit in REQ-023 uses the shadow values held before that edge and clears pending.
REQ-025 A capture coinciding with a commit edge is written to shadow and leaves pending=1, so it commits on the next frame_start_in.
REQ-026 A frame_start_in with pending=0 leaves the active slots unchanged.
REQ-027 color_out is registered: color_out = active[zone_in] from the previous cycle, fixed latency 1.
REQ-028 Active slots change only on commit edges, so no zone changes colour mid-frame.
REQ-029 pending_out equals the internal pending flag.

Reset
REQ-030 reset_in=1 asynchronously forces: FSM=IDLE, debounce and auto counters=0, load_sel_out=0, pending_out=0, color_out=24'h000000.
REQ-031 reset_in=1 also forces active and shadow slots to defaults: slot0=24'hFF0000, slot1=24'h00FF00, slot2=24'h0000FF, slot3=24'hFFFFFF.
REQ-032 Reset asserted mid-debounce or mid-pending discards the in-progress press and any uncommitted captures.
REQ-033 The first rising clock edge after reset_in deasserts performs normal operation.

Verification
REQ-034 Reset, then zone_in=2 held -> color_out=24'h0000FF one cycle later; load_sel_out=0; pending_out=0.
REQ-035 DEBOUNCE_CYCLES=16: swap_in high 15 cycles, then low -> no capture, load_sel_out stays 0.
REQ-036 DEBOUNCE_CYCLES=16: swap_in high 40 cycles with new_color_in=24'h123456 at the qualifying cycle -> single capture to slot0, load_sel_out=1, pending_out=1. Then frame_start_in pulse -> pending_out=0, and zone_in=0 reads 24'h123456 one cycle after the commit.
REQ-037 Five qualified presses -> load_sel_out sequence 1,2,3,0,1; slot0 holds the fifth captured colour after commit.
REQ-038 auto_en_in=1, AUTO_PERIOD=3, qualified press landing on the 3rd frame_start_in edge -> exactly one capture, load_sel_out +1. The pre-edge shadow commits and pending_out stays 1 until the 4th frame_start_in.
REQ-039 reset_in asserted asynchronously between clock edges while pending_out=1 -> all outputs take their reset values immediately, and zone3 reads 24'hFFFFFF afterwards.
